// File: rtl/atm_controller.sv
// Single-card ATM control FSM: card accept, PIN check with retry limit,
// balance display and withdrawal against an internal 5-bit balance.
module atm_controller #(
   parameter logic [3:0] PIN          = 4'd5,
   parameter logic [4:0] INIT_BALANCE = 5'd20,
   parameter logic [1:0] MAX_TRIES    = 2'd3
) (
   input  logic       Clock,
   input  logic       Clear,
   input  logic       CardIn,
   input  logic       Eject,
   input  logic       Submit,
   input  logic [3:0] Password,
   input  logic [4:0] Value,
   input  logic       ShowBalance,
   input  logic       Withdraw,
   output logic [4:0] BalanceValue,
   output logic       Ready,
   output logic       Working,
   output logic       ErrPass,
   output logic       ErrValue,
   output logic [3:0] State,
   output logic [3:0] NextState
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_PASS     = 4'd1,
      S_PASS_ERR = 4'd2,
      S_MENU     = 4'd3,
      S_BALANCE  = 4'd4,
      S_WITHDRAW = 4'd5,
      S_VAL_ERR  = 4'd6,
      S_EJECT    = 4'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] tries_q, tries_d;
   logic [4:0] balance_q, balance_d;
   logic [4:0] bal_val_q, bal_val_d;
   logic       ready_q, working_q, err_pass_q, err_value_q;
   logic       in_session;

   assign in_session = (state_q inside {S_PASS, S_PASS_ERR, S_MENU,
                                        S_BALANCE, S_WITHDRAW, S_VAL_ERR});

   always_comb begin
      state_d   = state_q;
      tries_d   = tries_q;
      balance_d = balance_q;
      bal_val_d = bal_val_q;
      // Card removal or eject request aborts any active session outright.
      if (in_session && (Eject || !CardIn)) begin
         state_d = S_EJECT;
      end else begin
         case (state_q)
            S_IDLE:     state_d = CardIn ? S_PASS : S_IDLE;
            S_PASS: begin
               if (Submit) begin
                  if (Password == PIN) begin
                     state_d = S_MENU;
                     tries_d = 2'd0;
                  end else begin
                     state_d = S_PASS_ERR;
                     tries_d = tries_q + 2'd1;
                  end
               end
            end
            S_PASS_ERR: state_d = (tries_q == MAX_TRIES) ? S_EJECT : S_PASS;
            S_MENU: begin
               if (ShowBalance)   state_d = S_BALANCE;
               else if (Withdraw) state_d = S_WITHDRAW;
            end
            S_BALANCE:  state_d = S_MENU;
            S_WITHDRAW: begin
               if (Submit) begin
                  if ((Value != 5'd0) && (Value <= balance_q)) begin
                     balance_d = balance_q - Value;
                     bal_val_d = balance_q - Value;
                     state_d   = S_MENU;
                  end else begin
                     state_d = S_VAL_ERR;
                  end
               end
            end
            S_VAL_ERR:  state_d = S_MENU;
            S_EJECT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
         endcase
      end
      if (state_q == S_BALANCE) bal_val_d = balance_q;
      if (state_q == S_EJECT)   tries_d   = 2'd0;
   end

   // Moore outputs are decoded from the next state so they line up with State.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q     <= S_IDLE;
         tries_q     <= 2'd0;
         balance_q   <= INIT_BALANCE;
         bal_val_q   <= 5'd0;
         ready_q     <= 1'b1;
         working_q   <= 1'b0;
         err_pass_q  <= 1'b0;
         err_value_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tries_q     <= tries_d;
         balance_q   <= balance_d;
         bal_val_q   <= bal_val_d;
         ready_q     <= (state_d == S_IDLE);
         working_q   <= (state_d inside {S_PASS, S_PASS_ERR, S_MENU,
                                         S_BALANCE, S_WITHDRAW, S_VAL_ERR});
         err_pass_q  <= (state_d == S_PASS_ERR);
         err_value_q <= (state_d == S_VAL_ERR);
      end
   end

   assign State        = state_q;
   assign NextState    = state_d;
   assign BalanceValue = bal_val_q;
   assign Ready        = ready_q;
   assign Working      = working_q;
   assign ErrPass      = err_pass_q;
   assign ErrValue     = err_value_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed walk through the ATM sessions followed by randomized traffic,
// all checked cycle by cycle against a behavioural model.
module tb_atm_controller;

   logic       Clock = 1'b0;
   logic       Clear, CardIn, Eject, Submit, ShowBalance, Withdraw;
   logic [3:0] Password;
   logic [4:0] Value;
   logic [4:0] BalanceValue;
   logic       Ready, Working, ErrPass, ErrValue;
   logic [3:0] State, NextState;

   int checks   = 0;
   int failures = 0;

   // Model state: plain integers following the written transition rules.
   int m_state, m_tries, m_bal, m_bv;

   atm_controller dut (
      .Clock(Clock), .Clear(Clear), .CardIn(CardIn), .Eject(Eject),
      .Submit(Submit), .Password(Password), .Value(Value),
      .ShowBalance(ShowBalance), .Withdraw(Withdraw),
      .BalanceValue(BalanceValue), .Ready(Ready), .Working(Working),
      .ErrPass(ErrPass), .ErrValue(ErrValue), .State(State),
      .NextState(NextState)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_next();
      if (m_state >= 1 && m_state <= 6 && (Eject || !CardIn)) return 7;
      case (m_state)
         0: return CardIn ? 1 : 0;
         1: return !Submit ? 1 : ((Password == 4'd5) ? 3 : 2);
         2: return (m_tries == 3) ? 7 : 1;
         3: return ShowBalance ? 4 : (Withdraw ? 5 : 3);
         4: return 3;
         5: begin
            if (!Submit) return 5;
            return (Value != 0 && int'(Value) <= m_bal) ? 3 : 6;
         end
         6: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_tries = 0; m_bal = 20; m_bv = 0;
   endtask

   task automatic model_clock();
      int n;
      if (Clear) begin
         model_reset();
      end else begin
         n = model_next();
         if (m_state == 1 && n == 3) m_tries = 0;
         if (m_state == 1 && n == 2) m_tries = m_tries + 1;
         if (m_state == 7) m_tries = 0;
         if (m_state == 4) m_bv = m_bal;
         if (m_state == 5 && n == 3) begin
            m_bal = m_bal - int'(Value);
            m_bv  = m_bal;
         end
         m_state = n;
      end
   endtask

   // One clock: compare everything mid-cycle, then advance DUT and model.
   task automatic step();
      @(negedge Clock);
      check("state",    State,        m_state);
      check("next",     NextState,    model_next());
      check("ready",    Ready,        (m_state == 0));
      check("working",  Working,      (m_state >= 1 && m_state <= 6));
      check("errpass",  ErrPass,      (m_state == 2));
      check("errvalue", ErrValue,     (m_state == 6));
      check("balvalue", BalanceValue, m_bv);
      @(posedge Clock);
      model_clock();
      #1;
   endtask

   initial begin
      Clear = 1'b1; CardIn = 1'b0; Eject = 1'b0; Submit = 1'b0;
      ShowBalance = 1'b0; Withdraw = 1'b0; Password = 4'd0; Value = 5'd0;
      @(posedge Clock);
      model_reset();
      #1;
      step();
      Clear = 1'b0;
      repeat (10) step();
      check("t1_state", State, 0);
      check("t1_ready", Ready, 1);
      check("t1_bv",    BalanceValue, 0);

      // Card in, correct PIN.
      CardIn = 1'b1; step();
      check("t2_pass", State, 1);
      check("t2_working", Working, 1);
      Password = 4'd5; Submit = 1'b1; step();
      Submit = 1'b0;
      check("t2_menu", State, 3);

      // Balance display.
      ShowBalance = 1'b1; step();
      ShowBalance = 1'b0;
      check("t3_balance", State, 4);
      step();
      check("t3_menu", State, 3);
      check("t3_bv", BalanceValue, 20);

      // Good withdrawal, then one exceeding the balance.
      Withdraw = 1'b1; step();
      Withdraw = 1'b0;
      check("t4_wd", State, 5);
      Value = 5'd7; Submit = 1'b1; step();
      Submit = 1'b0;
      check("t4_menu", State, 3);
      check("t4_bv13", BalanceValue, 13);
      Withdraw = 1'b1; step();
      Withdraw = 1'b0;
      Value = 5'd14; Submit = 1'b1; step();
      Submit = 1'b0;
      check("t4_valerr", State, 6);
      check("t4_errvalue", ErrValue, 1);
      step();
      check("t4_back", State, 3);
      ShowBalance = 1'b1; step();
      ShowBalance = 1'b0; step();
      check("t4_bal13", BalanceValue, 13);

      // Exact full-balance withdrawal is legal.
      Withdraw = 1'b1; step();
      Withdraw = 1'b0;
      Value = 5'd13; Submit = 1'b1; step();
      Submit = 1'b0;
      check("full_wd_bv", BalanceValue, 0);
      check("full_wd_state", State, 3);

      // Remove card, then three wrong PINs eject it.
      CardIn = 1'b0; step();
      check("t5_eject0", State, 7);
      step();
      CardIn = 1'b1; step();
      Password = 4'd3;
      for (int i = 0; i < 3; i++) begin
         Submit = 1'b1; step();
         Submit = 1'b0;
         check("t5_passerr", State, 2);
         check("t5_errpass", ErrPass, 1);
         if (i == 2) CardIn = 1'b0;
         step();
      end
      check("t5_eject", State, 7);
      step();
      check("t5_idle", State, 0);
      check("t5_ready", Ready, 1);

      // Eject during withdrawal, then Clear mid-session restores the balance.
      CardIn = 1'b1; step();
      Password = 4'd5; Submit = 1'b1; step();
      Submit = 1'b0;
      Withdraw = 1'b1; step();
      Withdraw = 1'b0;
      check("t6_wd", State, 5);
      Eject = 1'b1; step();
      Eject = 1'b0;
      check("t6_eject", State, 7);
      step();
      check("t6_idle", State, 0);
      step();
      Submit = 1'b1; step();
      Submit = 1'b0;
      check("t6_menu", State, 3);
      Clear = 1'b1; step();
      Clear = 1'b0;
      check("t6_clear", State, 0);
      step();
      Submit = 1'b1; step();
      Submit = 1'b0;
      ShowBalance = 1'b1; step();
      ShowBalance = 1'b0; step();
      check("t6_bal20", BalanceValue, 20);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         Clear       = ($urandom_range(63) == 0);
         CardIn      = ($urandom_range(15) != 0);
         Eject       = ($urandom_range(31) == 0);
         Submit      = $urandom_range(1) == 1;
         ShowBalance = ($urandom_range(3) == 0);
         Withdraw    = $urandom_range(1) == 1;
         Password    = ($urandom_range(1) == 1) ? 4'd5 : 4'($urandom_range(15));
         Value       = 5'($urandom_range(24));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
